// File: rtl/gb_oam_dma.sv
`default_nettype none
// ============================================================================
// Module      : gb_oam_dma
// Description : Game Boy OAM DMA engine. A CPU write to $FF46 selects a source
//               page; after one delay M-cycle the engine reads Length bytes
//               from {page, 00..Length-1} over the memory bus and writes them
//               into OAM, one byte per M-cycle with zero-wait memory. The OAM
//               write of byte n overlaps the bus read of byte n+1. Source pages
//               $E0-$FF fold onto $C0-$DF (echo RAM).
//
// Ports       : Clk             system clock
//               Reset_n         synchronous active-low reset (ignores ClkEn)
//               ClkEn           M-cycle enable; state advances only when high
//               RegWrite        CPU write strobe to $FF46
//               RegData         CPU write data (source page)
//               RegRead         last value written to $FF46
//               BusAccess       read request to the bus controller
//               BusWrite        tied low, reads only
//               BusAddress      source address of the current read
//               BusDToInitiator read data from the bus controller
//               BusReady        request accepted this cycle
//               BusDataReady    BusDToInitiator valid this cycle
//               OamWrite        single-cycle OAM write strobe
//               OamAddress      OAM byte index
//               OamData         OAM write data
//               Active          transfer in progress
//
// Revision    : 1.0  initial release
// ============================================================================
module gb_oam_dma #(
    parameter string DeviceType = "Xilinx",
    parameter int    Length     = 160
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        ClkEn,
    input  logic        RegWrite,
    input  logic [7:0]  RegData,
    output logic [7:0]  RegRead,
    output logic        BusAccess,
    output logic        BusWrite,
    output logic [15:0] BusAddress,
    input  logic [7:0]  BusDToInitiator,
    input  logic        BusReady,
    input  logic        BusDataReady,
    output logic        OamWrite,
    output logic [7:0]  OamAddress,
    output logic [7:0]  OamData,
    output logic        Active
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DELAY = 2'd1;
    localparam logic [1:0] c_ST_XFER  = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    localparam logic [7:0] c_LAST_IDX = 8'(Length - 1);

    logic [1:0] r_state;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic       r_outst;      // request accepted, data not yet returned
    logic       r_oam_wr;     // captured byte waiting for its OAM write
    logic [7:0] r_oam_addr;
    logic [7:0] r_oam_data;

    logic [7:0] w_src_page;
    logic       w_in_xfer;

    // Echo-RAM fold: pages $E0-$FF read from $C0-$DF. Both forms give
    // page-$20 for that range and pass every other page through unchanged.
    generate
        if (DeviceType == "Xilinx") begin : g_fold_sub
            assign w_src_page = (r_page >= 8'hE0) ? (r_page - 8'h20) : r_page;
        end else begin : g_fold_mask
            assign w_src_page = {r_page[7:6], r_page[5] & ~(&r_page[7:5]), r_page[4:0]};
        end
    endgenerate

    assign w_in_xfer = (r_state == c_ST_XFER);

    // All outputs derive from state that only moves on ClkEn, so they hold
    // while ClkEn is low. OamWrite alone is gated so the strobe lasts one Clk.
    assign RegRead    = r_page;
    assign Active     = (r_state != c_ST_IDLE);
    assign BusWrite   = 1'b0;
    assign BusAccess  = w_in_xfer && !r_outst;
    assign BusAddress = w_in_xfer ? {w_src_page, r_idx} : 16'h0000;
    assign OamWrite   = r_oam_wr && ClkEn;
    assign OamAddress = r_oam_addr;
    assign OamData    = r_oam_data;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state    <= c_ST_IDLE;
            r_page     <= 8'hFF;
            r_idx      <= 8'h00;
            r_outst    <= 1'b0;
            r_oam_wr   <= 1'b0;
            r_oam_addr <= 8'h00;
            r_oam_data <= 8'h00;
        end else if (ClkEn) begin
            // The pending strobe is consumed on this edge; a new capture below
            // re-arms it for the next M-cycle.
            r_oam_wr <= 1'b0;
            if (RegWrite) begin
                // A new write (in any state) restarts from byte 0. Leaving
                // r_oam_wr cleared drops any byte captured for the old page.
                r_page  <= RegData;
                r_idx   <= 8'h00;
                r_outst <= 1'b0;
                r_state <= c_ST_DELAY;
            end else begin
                case (r_state)
                    c_ST_DELAY: r_state <= c_ST_XFER;
                    c_ST_XFER: begin
                        if (BusDataReady) begin
                            r_outst    <= 1'b0;
                            r_oam_wr   <= 1'b1;
                            r_oam_addr <= r_idx;
                            r_oam_data <= BusDToInitiator;
                            if (r_idx == c_LAST_IDX) begin
                                r_state <= c_ST_DRAIN;
                            end else begin
                                r_idx <= r_idx + 8'd1;
                            end
                        end else if (BusAccess && BusReady) begin
                            // Accepted without data: stop requesting until
                            // the byte returns so only one read is in flight.
                            r_outst <= 1'b1;
                        end
                    end
                    c_ST_DRAIN: r_state <= c_ST_IDLE;
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gb_oam_dma.sv
`default_nettype none
// ============================================================================
// Module      : tb_gb_oam_dma
// Description : Self-checking bench for gb_oam_dma. A bus model serves reads
//               from a random 64 KiB memory image; each CPU write pushes the
//               160 expected OAM (index, byte) pairs into a scoreboard queue
//               that a monitor drains as OamWrite strobes appear.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gb_oam_dma;

    localparam int c_LEN = 160;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        ClkEn;
    logic        RegWrite;
    logic [7:0]  RegData;
    logic [7:0]  RegRead;
    logic        BusAccess;
    logic        BusWrite;
    logic [15:0] BusAddress;
    logic [7:0]  BusDToInitiator = 8'h00;
    logic        BusReady = 1'b0;
    logic        BusDataReady = 1'b0;
    logic        OamWrite;
    logic [7:0]  OamAddress;
    logic [7:0]  OamData;
    logic        Active;

    gb_oam_dma #(
        .DeviceType ("Xilinx"),
        .Length     (c_LEN)
    ) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .ClkEn           (ClkEn),
        .RegWrite        (RegWrite),
        .RegData         (RegData),
        .RegRead         (RegRead),
        .BusAccess       (BusAccess),
        .BusWrite        (BusWrite),
        .BusAddress      (BusAddress),
        .BusDToInitiator (BusDToInitiator),
        .BusReady        (BusReady),
        .BusDataReady    (BusDataReady),
        .OamWrite        (OamWrite),
        .OamAddress      (OamAddress),
        .OamData         (OamData),
        .Active          (Active)
    );

    always #5 Clk = ~Clk;

    logic [7:0]  mem [0:65535];
    logic [15:0] exp_q [$];          // {oam index, data}
    int n_tests = 0;
    int n_fail  = 0;

    // ClkEn-cycle bookkeeping, relative to the cycle the last write was issued
    int ecyc = 0;
    int t0   = 0;
    int mon_rel;
    int act_first, act_last, rd_first, rd_last, wr_first, wr_last;
    int wr_n = 0;
    int rd_n = 0;
    int wr_cyc [0:255];
    logic [15:0] rd_base = 16'h0000;
    logic [15:0] rd_first_addr, rd_last_addr;

    int en_mode  = 0;    // 0: ClkEn always, 1: one of four, 2: random
    int div      = 0;
    int bus_mode = 0;    // 0: zero wait, 1: random waits, 2: byte 10 held 3 cycles

    logic        pend = 1'b0;
    logic [15:0] paddr = 16'h0000;
    int          pdelay = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Memory bus model: accepts one request at a time, returns data after a
    // mode-dependent number of ClkEn cycles. Runs after outputs settle.
    always @(posedge Clk) begin
        #2;
        BusReady        = 1'b0;
        BusDataReady    = 1'b0;
        BusDToInitiator = 8'($urandom);
        if (ClkEn) begin
            if (!pend && BusAccess && (bus_mode != 1 || $urandom_range(0, 3) != 0)) begin
                BusReady = 1'b1;
                paddr    = BusAddress;
                pend     = 1'b1;
                case (bus_mode)
                    0:       pdelay = 0;
                    1:       pdelay = $urandom_range(0, 2);
                    default: pdelay = (BusAddress[7:0] == 8'd10) ? 3 : 0;
                endcase
            end
            if (pend) begin
                if (pdelay == 0) begin
                    BusDataReady    = 1'b1;
                    BusDToInitiator = mem[paddr];
                    pend            = 1'b0;
                end else begin
                    pdelay--;
                end
            end
        end
        if (!Reset_n || (ClkEn && RegWrite)) pend = 1'b0;
    end

    // Monitor: scoreboard checks on OAM writes, read-address checks on
    // accepted requests, and timing capture per ClkEn cycle.
    always @(negedge Clk) begin
        if (!ClkEn) begin
            check("oamwrite_while_clken_low", OamWrite, 1'b0);
        end else begin
            mon_rel = ecyc - t0;
            check("buswrite", BusWrite, 1'b0);
            if (Active) begin
                if (act_first < 0) act_first = mon_rel;
                act_last = mon_rel;
            end
            if (BusAccess && BusReady) begin
                check("read_addr", BusAddress, rd_base + 16'(rd_n));
                if (rd_first < 0) begin
                    rd_first      = mon_rel;
                    rd_first_addr = BusAddress;
                end
                rd_last      = mon_rel;
                rd_last_addr = BusAddress;
                rd_n++;
            end
            if (OamWrite) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_oamwrite: got idx %0h data %0h, expected none", OamAddress, OamData);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("oam_index", OamAddress, e[15:8]);
                    check("oam_data", OamData, e[7:0]);
                end
                if (wr_first < 0) wr_first = mon_rel;
                wr_last = mon_rel;
                wr_cyc[OamAddress] = mon_rel;
                wr_n++;
            end
            ecyc++;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
        RegWrite = 1'b0;
        case (en_mode)
            0: ClkEn = 1'b1;
            1: begin
                ClkEn = (div == 0);
                div   = (div + 1) % 4;
            end
            default: ClkEn = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Issue a $FF46 write on the next ClkEn cycle and load the reference
    // result: OAM[i] = mem[{src, i}], src folding $E0-$FF down by $20.
    task automatic do_write(input logic [7:0] p);
        int k;
        logic [7:0] src;
        k = 0;
        do begin
            tick();
            k++;
        end while (!ClkEn && k < 100);
        RegWrite = 1'b1;
        RegData  = p;
        t0       = ecyc;
        @(negedge Clk);
        #1;
        exp_q.delete();
        src = (p >= 8'hE0) ? p - 8'h20 : p;
        for (int i = 0; i < c_LEN; i++) begin
            logic [15:0] addr;
            addr = {src, 8'(i)};
            exp_q.push_back({8'(i), mem[addr]});
        end
        rd_base   = {src, 8'h00};
        act_first = -1; act_last = -1;
        rd_first  = -1; rd_last  = -1;
        wr_first  = -1; wr_last  = -1;
        wr_n = 0;
        rd_n = 0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while ((Active || exp_q.size() != 0) && k < 5000);
        check({name, "_timeout"}, (k < 5000), 1'b1);
        check({name, "_sb_empty"}, exp_q.size(), 0);
        repeat (2) tick();
    endtask

    task automatic wait_writes(input int n);
        int k;
        k = 0;
        while (wr_n < n && k < 2000) begin
            tick();
            k++;
        end
        check("wait_writes_timeout", (k < 2000), 1'b1);
    endtask

    task automatic check_timing(input string name, input int extra);
        check({name, "_active_first"}, act_first, 1);
        check({name, "_active_last"},  act_last, 162 + extra);
        check({name, "_read_first"},   rd_first, 2);
        check({name, "_read_last"},    rd_last, 161 + extra);
        check({name, "_write_first"},  wr_first, 3);
        check({name, "_write_last"},   wr_last, 162 + extra);
        check({name, "_reads"},        rd_n, c_LEN);
        check({name, "_writes"},       wr_n, c_LEN);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        logic [7:0] pg;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) wr_cyc[i] = 0;
        act_first = -1; act_last = -1; rd_first = -1; rd_last = -1;
        wr_first = -1; wr_last = -1;
        Reset_n  = 1'b0;
        ClkEn    = 1'b0;
        RegWrite = 1'b0;
        RegData  = 8'h00;

        // Reset with ClkEn low: reset must still take effect
        repeat (3) begin
            @(posedge Clk);
            #1;
        end
        check("rst_regread",    RegRead, 8'hFF);
        check("rst_active",     Active, 1'b0);
        check("rst_busaccess",  BusAccess, 1'b0);
        check("rst_busaddress", BusAddress, 16'h0000);
        check("rst_oamwrite",   OamWrite, 1'b0);
        check("rst_oamaddress", OamAddress, 8'h00);
        check("rst_oamdata",    OamData, 8'h00);
        Reset_n = 1'b1;
        repeat (3) tick();

        // Zero-wait transfer from $C1
        en_mode = 0; bus_mode = 0;
        do_write(8'hC1);
        wait_done("c1");
        check_timing("c1", 0);
        check("c1_first_addr", rd_first_addr, 16'hC100);
        check("c1_last_addr",  rd_last_addr, 16'hC19F);

        // Echo page $FE reads from $DE00-$DE9F
        do_write(8'hFE);
        wait_done("fe");
        check("fe_first_addr", rd_first_addr, 16'hDE00);
        check("fe_last_addr",  rd_last_addr, 16'hDE9F);
        check("fe_regread",    RegRead, 8'hFE);

        // Byte 10 held back 3 cycles
        bus_mode = 2;
        do_write(8'h45);
        wait_done("stall");
        check_timing("stall", 3);
        check("stall_gap_9_10",  wr_cyc[10] - wr_cyc[9], 4);
        check("stall_gap_10_11", wr_cyc[11] - wr_cyc[10], 1);
        bus_mode = 0;

        // Restart from $90 while $80 is half done
        do_write(8'h80);
        wait_writes(50);
        do_write(8'h90);
        wait_done("restart");
        check("restart_first_addr", rd_first_addr, 16'h9000);
        check("restart_read_first", rd_first, 2);
        check("restart_writes",     wr_n, c_LEN);
        check("restart_write_last", wr_last, 162);
        check("restart_regread",    RegRead, 8'h90);

        // Reset mid-transfer
        do_write(8'h3A);
        wait_writes(80);
        tick();
        Reset_n = 1'b0;
        @(negedge Clk);
        #1;
        exp_q.delete();
        snap = wr_n;
        tick();
        check("midrst_active",    Active, 1'b0);
        check("midrst_busaccess", BusAccess, 1'b0);
        check("midrst_oamwrite",  OamWrite, 1'b0);
        check("midrst_regread",   RegRead, 8'hFF);
        Reset_n = 1'b1;
        repeat (20) tick();
        check("midrst_no_writes", wr_n - snap, 0);

        // ClkEn one cycle in four: same per-M-cycle sequence
        en_mode = 1; div = 0;
        do_write(8'hC1);
        wait_done("div4");
        check_timing("div4", 0);
        check("div4_first_addr", rd_first_addr, 16'hC100);

        // Random ClkEn and bus waits over random pages
        en_mode = 2; bus_mode = 1;
        for (int it = 0; it < 4; it++) begin
            pg = (it == 0) ? 8'($urandom_range(224, 255)) : 8'($urandom);
            do_write(pg);
            wait_done("random");
            check("random_reads",   rd_n, c_LEN);
            check("random_writes",  wr_n, c_LEN);
            check("random_regread", RegRead, pg);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
